// File: rtl/sd_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sd_residue_accumulator
// Brief    : Pipelined borrow-save (signed-digit) residue accumulator with an
//            optional doubling recurrence and a start/valid/done sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module sd_residue_accumulator #(
    parameter int BITS     = 4,
    parameter int DELAY    = 5,
    parameter int SHIFT_EN = 1,
    parameter int DIGITS   = 8,
    localparam int c_res_w = BITS + DELAY,
    localparam int c_cnt_w = $clog2(DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITS-1:0]    x_plus,
    input  logic [BITS-1:0]    x_minus,
    input  logic [BITS-1:0]    y_plus,
    input  logic [BITS-1:0]    y_minus,
    input  logic [1:0]         cin_x,
    input  logic [1:0]         cin_y,
    output logic [c_res_w-1:0] res_plus,
    output logic [c_res_w-1:0] res_minus,
    output logic               out_valid,
    output logic               done,
    output logic               busy,
    output logic [c_cnt_w-1:0] digit_cnt
);

    // Two extra digits so X+Y plus both carry-ins is held exactly.
    localparam int c_s1_w = BITS + 2;

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_run   = 2'd1;
    localparam logic [1:0] c_s_drain = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_s1_valid;
    logic [c_s1_w-1:0]   r_s1_plus;
    logic [c_s1_w-1:0]   r_s1_minus;
    logic [c_res_w-1:0]  r_res_plus;
    logic [c_res_w-1:0]  r_res_minus;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_out_valid;
    logic                r_done;

    logic                w_accept;
    logic                w_start;
    logic [c_s1_w-1:0]   w_s1_plus;
    logic [c_s1_w-1:0]   w_s1_minus;
    logic [c_res_w-1:0]  w_b_plus;
    logic [c_res_w-1:0]  w_b_minus;
    logic [c_res_w-1:0]  w_a_plus;
    logic [c_res_w-1:0]  w_a_minus;
    logic [c_res_w-1:0]  w_l1_sum;
    logic [c_res_w-2:0]  w_l1_cry;
    logic [c_res_w-1:0]  w_l1_cin;
    logic [c_res_w-1:0]  w_l2_sum;
    logic [c_res_w-2:0]  w_l2_cry;
    logic [c_res_w-1:0]  w_sum_plus;
    logic [c_res_w-1:0]  w_sum_minus;

    assign in_ready  = (r_state == c_s_run);
    assign busy      = (r_state != c_s_idle);
    assign w_accept  = in_valid & (r_state == c_s_run);
    assign w_start   = start & (r_state == c_s_idle);
    assign res_plus  = r_res_plus;
    assign res_minus = r_res_minus;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign digit_cnt = r_cnt;

    // Stage 1 sums plus and minus halves separately; this is off the feedback path.
    assign w_s1_plus  = {2'b00, x_plus} + {2'b00, y_plus}
                      + c_s1_w'(cin_x[1]) + c_s1_w'(cin_y[1]);
    assign w_s1_minus = {2'b00, x_minus} + {2'b00, y_minus}
                      + c_s1_w'(cin_x[0]) + c_s1_w'(cin_y[0]);

    generate
        if (c_res_w > c_s1_w) begin : g_ext_wide
            assign w_b_plus  = {{(c_res_w - c_s1_w){1'b0}}, r_s1_plus};
            assign w_b_minus = {{(c_res_w - c_s1_w){1'b0}}, r_s1_minus};
        end else if (c_res_w == c_s1_w) begin : g_ext_equal
            assign w_b_plus  = r_s1_plus;
            assign w_b_minus = r_s1_minus;
        end else begin : g_ext_narrow
            assign w_b_plus  = r_s1_plus[c_res_w-1:0];
            assign w_b_minus = r_s1_minus[c_res_w-1:0];
        end
    endgenerate

    // Carry-free SD add: A+ + B+ + ~A- + ~B- + 2 through two 3:2 layers.
    // One of the +1s enters layer 2's carry LSB, the other comes from
    // representing the final carry vector c as minus = ~(c<<1).
    always_comb begin
        if (SHIFT_EN != 0) begin
            w_a_plus  = {r_res_plus[c_res_w-2:0], 1'b0};
            w_a_minus = {r_res_minus[c_res_w-2:0], 1'b0};
        end else begin
            w_a_plus  = r_res_plus;
            w_a_minus = r_res_minus;
        end
        w_l1_sum    = w_a_plus ^ w_b_plus ^ ~w_a_minus;
        w_l1_cry    = (w_a_plus[c_res_w-2:0] & w_b_plus[c_res_w-2:0])
                    | (w_a_plus[c_res_w-2:0] & ~w_a_minus[c_res_w-2:0])
                    | (w_b_plus[c_res_w-2:0] & ~w_a_minus[c_res_w-2:0]);
        w_l1_cin    = {w_l1_cry, 1'b1};
        w_l2_sum    = w_l1_sum ^ w_l1_cin ^ ~w_b_minus;
        w_l2_cry    = (w_l1_sum[c_res_w-2:0] & w_l1_cin[c_res_w-2:0])
                    | (w_l1_sum[c_res_w-2:0] & ~w_b_minus[c_res_w-2:0])
                    | (w_l1_cin[c_res_w-2:0] & ~w_b_minus[c_res_w-2:0]);
        w_sum_plus  = w_l2_sum;
        w_sum_minus = ~{w_l2_cry, 1'b0};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: begin
                if (start) w_state_nxt = c_s_run;
            end
            c_s_run: begin
                if (w_accept && (r_cnt == c_cnt_w'(DIGITS - 1))) w_state_nxt = c_s_drain;
            end
            c_s_drain: begin
                if (r_done) w_state_nxt = c_s_idle;
            end
            default: w_state_nxt = c_s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_s_idle;
            r_s1_valid  <= 1'b0;
            r_s1_plus   <= '0;
            r_s1_minus  <= '0;
            r_res_plus  <= '0;
            r_res_minus <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s1_valid  <= w_accept;
            r_out_valid <= r_s1_valid;
            // Only the final beat can occupy stage 1 while draining.
            r_done      <= r_s1_valid & (r_state == c_s_drain);
            if (w_accept) begin
                r_s1_plus  <= w_s1_plus;
                r_s1_minus <= w_s1_minus;
            end
            if (w_start) begin
                r_res_plus  <= '0;
                r_res_minus <= '0;
                r_cnt       <= '0;
            end else begin
                if (r_s1_valid) begin
                    r_res_plus  <= w_sum_plus;
                    r_res_minus <= w_sum_minus;
                end
                if (w_accept) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_residue_accumulator
// Brief    : Self-checking bench for sd_residue_accumulator across four
//            parameter sets against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_residue_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] st;
    logic       in_valid;
    logic [3:0] xp, xm, yp, ym;
    logic [1:0] cx, cy;

    logic [8:0] rp [4];
    logic [8:0] rm [4];
    logic       ir [4];
    logic       ov [4];
    logic       dn [4];
    logic       bz [4];
    logic [0:0] dc0;
    logic [1:0] dc1;
    logic [3:0] dc2;
    logic [2:0] dc3;
    int         dcnt [4];

    always #5 clk = ~clk;

    always_comb begin
        dcnt[0] = int'(dc0);
        dcnt[1] = int'(dc1);
        dcnt[2] = int'(dc2);
        dcnt[3] = int'(dc3);
    end

    sd_residue_accumulator #(.BITS(4), .DELAY(5), .SHIFT_EN(0), .DIGITS(1)) u0 (
        .clk(clk), .reset(reset), .start(st[0]), .in_valid(in_valid), .in_ready(ir[0]),
        .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym), .cin_x(cx), .cin_y(cy),
        .res_plus(rp[0]), .res_minus(rm[0]), .out_valid(ov[0]), .done(dn[0]),
        .busy(bz[0]), .digit_cnt(dc0));
    sd_residue_accumulator #(.BITS(4), .DELAY(5), .SHIFT_EN(1), .DIGITS(3)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .in_valid(in_valid), .in_ready(ir[1]),
        .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym), .cin_x(cx), .cin_y(cy),
        .res_plus(rp[1]), .res_minus(rm[1]), .out_valid(ov[1]), .done(dn[1]),
        .busy(bz[1]), .digit_cnt(dc1));
    sd_residue_accumulator #(.BITS(4), .DELAY(5), .SHIFT_EN(0), .DIGITS(8)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .in_valid(in_valid), .in_ready(ir[2]),
        .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym), .cin_x(cx), .cin_y(cy),
        .res_plus(rp[2]), .res_minus(rm[2]), .out_valid(ov[2]), .done(dn[2]),
        .busy(bz[2]), .digit_cnt(dc2));
    sd_residue_accumulator #(.BITS(4), .DELAY(5), .SHIFT_EN(1), .DIGITS(4)) u3 (
        .clk(clk), .reset(reset), .start(st[3]), .in_valid(in_valid), .in_ready(ir[3]),
        .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym), .cin_x(cx), .cin_y(cy),
        .res_plus(rp[3]), .res_minus(rm[3]), .out_valid(ov[3]), .done(dn[3]),
        .busy(bz[3]), .digit_cnt(dc3));

    typedef struct {
        int xp; int xm; int yp; int ym; int cx; int cy; int ev;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   c_sh [4] = '{0, 1, 0, 1};
    int   c_nd [4] = '{1, 3, 8, 4};
    int   bxp [16], bxm [16], byp [16], bym [16], bcx [16], bcy [16];
    bit   vpat [64];
    bit   spat [64];
    int   vlast;
    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int val(input int k);
        logic [8:0] d;
        d = rp[k] - rm[k];
        return int'($signed(d));
    endfunction

    // Reduce to a 9-bit residue and read it back as signed.
    function automatic int wrap9(input int v);
        int w;
        w = ((v % 512) + 512) % 512;
        return (w >= 256) ? w - 512 : w;
    endfunction

    function automatic int cinv(input int c);
        return ((c >> 1) & 1) - (c & 1);
    endfunction

    task automatic drive_junk();
        xp = 4'($urandom); xm = 4'($urandom); yp = 4'($urandom); ym = 4'($urandom);
        cx = 2'($urandom); cy = 2'($urandom);
    endtask

    task automatic fill_rand(input int vprob, input int sprob);
        for (int i = 0; i < 16; i++) begin
            bxp[i] = int'($urandom_range(15, 0)); bxm[i] = int'($urandom_range(15, 0));
            byp[i] = int'($urandom_range(15, 0)); bym[i] = int'($urandom_range(15, 0));
            bcx[i] = int'($urandom_range(3, 0));  bcy[i] = int'($urandom_range(3, 0));
        end
        for (int i = 0; i < 64; i++) begin
            vpat[i] = (i >= 40) || ($urandom_range(99, 0) < vprob);
            spat[i] = ($urandom_range(99, 0) < sprob);
        end
    endtask

    // One full operation on instance k, checked cycle by cycle against the model.
    task automatic op(input int k, input string nm);
        int  cnt, last, vmod, sh, nd;
        bit  e_ov [70];
        int  e_val [70];
        sh = c_sh[k];
        nd = c_nd[k];
        for (int i = 0; i < 70; i++) begin
            e_ov[i]  = 1'b0;
            e_val[i] = 0;
        end
        in_valid = 1'b0;
        st[k] = 1'b1;
        step();
        st[k] = 1'b0;
        cnt = 0; vmod = 0; last = 1000;
        chk({nm, " cleared V"}, val(k), 0);
        chk({nm, " cleared cnt"}, dcnt[k], 0);
        for (int r = 0; r < 64 && r <= last + 1; r++) begin
            if (r <= last) begin
                chk({nm, " in_ready"}, int'(ir[k]), int'(cnt < nd));
                chk({nm, " busy"}, int'(bz[k]), 1);
            end else begin
                chk({nm, " in_ready idle"}, int'(ir[k]), 0);
                chk({nm, " busy idle"}, int'(bz[k]), 0);
            end
            chk({nm, " out_valid"}, int'(ov[k]), int'(e_ov[r]));
            chk({nm, " done"}, int'(dn[k]), int'(r == last));
            if (e_ov[r]) chk({nm, " V"}, val(k), e_val[r]);
            in_valid = vpat[r];
            st[k] = spat[r] && (r <= last);
            if (vpat[r] && cnt < nd) begin
                xp = 4'(bxp[cnt]); xm = 4'(bxm[cnt]); yp = 4'(byp[cnt]); ym = 4'(bym[cnt]);
                cx = 2'(bcx[cnt]); cy = 2'(bcy[cnt]);
                vmod = wrap9((sh != 0 ? 2 * vmod : vmod) + (bxp[cnt] - bxm[cnt])
                             + (byp[cnt] - bym[cnt]) + cinv(bcx[cnt]) + cinv(bcy[cnt]));
                e_ov[r+2]  = 1'b1;
                e_val[r+2] = vmod;
                cnt++;
                if (cnt == nd) last = r + 2;
            end else begin
                drive_junk();
            end
            step();
        end
        st[k] = 1'b0;
        in_valid = 1'b0;
        chk({nm, " final cnt"}, dcnt[k], nd);
        vlast = vmod;
    endtask

    task automatic idle_hold(input int k, input string nm);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive_junk();
            step();
            chk({nm, " idle out_valid"}, int'(ov[k]), 0);
            chk({nm, " idle V held"}, val(k), vlast);
            chk({nm, " idle cnt held"}, dcnt[k], c_nd[k]);
        end
        in_valid = 1'b0;
    endtask

    task automatic set_beats(input int n, input int a, input int b, input int c, input int d,
                             input int e, input int f);
        for (int i = 0; i < n; i++) begin
            bxp[i] = a; bxm[i] = b; byp[i] = c; bym[i] = d; bcx[i] = e; bcy[i] = f;
        end
        for (int i = 0; i < 64; i++) begin
            vpat[i] = 1'b1;
            spat[i] = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{5, 0, 0, 3, 0, 0, 2};
        tbl[1] = '{0, 0, 0, 0, 2, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 2, 3, 1};
        tbl[3] = '{15, 0, 15, 0, 2, 2, 32};
        tbl[4] = '{0, 15, 0, 15, 1, 1, -32};
        tbl[5] = '{10, 5, 15, 15, 0, 0, 5};

        reset = 1'b1; st = 4'hF; in_valid = 1'b1;
        xp = '0; xm = '0; yp = '0; ym = '0; cx = '0; cy = '0;
        step(); step();
        reset = 1'b0; st = 4'h0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset%0d res_plus", k), int'(rp[k]), 0);
            chk($sformatf("reset%0d res_minus", k), int'(rm[k]), 0);
            chk($sformatf("reset%0d busy", k), int'(bz[k]), 0);
            chk($sformatf("reset%0d in_ready", k), int'(ir[k]), 0);
            chk($sformatf("reset%0d cnt", k), dcnt[k], 0);
        end
        step();
        for (int k = 0; k < 4; k++) chk($sformatf("post-reset%0d busy", k), int'(bz[k]), 0);

        // Single-beat vectors with hand-computed values.
        for (int i = 0; i < 6; i++) begin
            set_beats(1, tbl[i].xp, tbl[i].xm, tbl[i].yp, tbl[i].ym, tbl[i].cx, tbl[i].cy);
            op(0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table V", i), val(0), tbl[i].ev);
        end

        set_beats(3, 1, 0, 0, 0, 0, 0);
        op(1, "shift3");
        chk("shift3 table V", val(1), 7);

        set_beats(8, 15, 0, 15, 0, 2, 2);
        op(2, "wrap");
        chk("wrap table V", val(2), -256);

        fill_rand(100, 0);
        for (int i = 0; i < 64; i++) vpat[i] = 1'b1;
        vpat[1] = 1'b0; vpat[4] = 1'b0; spat[1] = 1'b1; spat[3] = 1'b1;
        op(3, "bubbles");
        idle_hold(3, "bubbles");

        // Reset after two accepted beats, then a fresh operation.
        st[3] = 1'b1; step(); st[3] = 1'b0;
        in_valid = 1'b1; xp = 4'd3; xm = 4'd0; yp = 4'd2; ym = 4'd0; cx = 2'b10; cy = 2'b00;
        step(); step();
        in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
        chk("midreset res_plus", int'(rp[3]), 0);
        chk("midreset res_minus", int'(rm[3]), 0);
        chk("midreset out_valid", int'(ov[3]), 0);
        chk("midreset done", int'(dn[3]), 0);
        chk("midreset busy", int'(bz[3]), 0);
        chk("midreset in_ready", int'(ir[3]), 0);
        chk("midreset cnt", dcnt[3], 0);
        step();
        chk("midreset flushed out_valid", int'(ov[3]), 0);
        chk("midreset flushed V", val(3), 0);
        fill_rand(70, 10);
        op(3, "after_reset");

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 5; n++) begin
                fill_rand(75, 10);
                op(k, $sformatf("rand_u%0d_op%0d", k, n));
            end
            idle_hold(k, $sformatf("rand_u%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
